dcache_assoc: RTL and testbench
===============================

Name: dcache_assoc

Overview:
- Parametrised write-back, write-allocate data cache for the 8-bit CPU; sits between the CPU load/store path and the block-wide data memory.
- Generalises the direct-mapped cache to N-way set-associative (1 or 2 ways) with configurable set count and block size.
- Adds LRU replacement and a fully synchronous controller: all state updates happen on the clk edge, no delay-based sequencing.

Parameters:
- ADDR_W, 8, CPU byte-address width.
- NUM_SETS, 4, number of sets; power of two, ≥2.
- WAYS, 2, associativity; legal values 1 or 2.
- BLOCK_BYTES, 4, bytes per block; power of two, ≥2.
- Derived:
  - OFF_W = log2(BLOCK_BYTES).
  - IDX_W = log2(NUM_SETS).
  - TAG_W = ADDR_W-IDX_W-OFF_W.
  - BLK_W = 8*BLOCK_BYTES.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- read  in  1  CPU load request, held until busywait low
- write  in  1  CPU store request, held until busywait low
- address  in  ADDR_W  CPU byte address {tag,index,offset}
- writedata  in  8  store byte
- readdata  out  8  load byte, combinational from hit way
- busywait  out  1  stall CPU
- mem_read  out  1  block fetch strobe
- mem_write  out  1  block write-back strobe
- mem_address  out  ADDR_W-OFF_W  block address {tag,index}
- mem_writedata  out  BLK_W  victim block
- mem_readdata  in  BLK_W  fetched block
- mem_busywait  in  1  memory busy; high from the strobe cycle until data done

Behaviour:
- Reset (async): state=IDLE; all valid, dirty and LRU bits cleared; mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, busywait=0. Data and tag arrays are not cleared.
- Hit: valid && tag match in any way of set[index]. Evaluated combinationally in IDLE.
- readdata: selected byte of the hit way; 0 when no hit.
- busywait = (read|write) && !(state==IDLE && hit). Hit costs 0 stall cycles.
- Write hit:
  - Byte is merged at the posedge.
  - Line dirty bit is set.
  - CPU drops write after that edge.
- Any hit: at the posedge, LRU[set] is set to point at the other way. With WAYS=1 the LRU bit is unused.
- read && write both high: treated as a write.
- Victim selection on miss: the lowest-numbered invalid way; otherwise the LRU way. Latched on leaving IDLE.
- FSM transitions:
  - IDLE -> miss, victim dirty -> WRITEBACK.
  - IDLE -> miss, victim clean -> FETCH.
  - IDLE -> otherwise stay.
- WRITEBACK:
  - Outputs: mem_write=1, mem_address={victim tag,index}, mem_writedata=victim block.
  - At a posedge with mem_busywait=0 -> FETCH.
- FETCH:
  - Outputs: mem_read=1, mem_address={req tag,index}.
  - At a posedge with mem_busywait=0: victim data=mem_readdata, tag=req tag, valid=1, dirty=0; -> IDLE.
- After refill, the request hits in IDLE on the next cycle; a write then merges and sets dirty.
- Clean miss latency: mem latency + 1 cycle.
- Dirty miss latency: 2×mem latency + 1 cycle.
- The request (address, writedata) must be stable while busywait=1. The cache samples it live; it does not capture it.
- Reset mid-WRITEBACK or mid-FETCH:
  - Strobes drop immediately.
  - The refill is discarded.
  - All lines become invalid.
- The cache never asserts mem_read and mem_write together.
- mem strobes are 0 in IDLE.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined, adds two outputs: hit_count[15:0] and miss_count[15:0].
  - hit_count increments on each IDLE-state access that hits (one count per request, at the completing edge).
  - miss_count increments on each IDLE->WRITEBACK/FETCH transition.
  - Both saturate at 16'hFFFF and are cleared by reset.
- When undefined, the ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Cold read 0x25 after reset (mem latency 5):
  - FETCH with mem_address=0x09.
  - busywait high for 6 cycles.
  - readdata = byte 1 of the returned block.
- Read 0x24 after that fill -> busywait stays 0 and the correct byte returns the same cycle; miss_count unchanged, hit_count +1.
- Write 0xAB to 0x25, then misses to 0x45 and 0x65 (same set):
  - 0x45 fills way1.
  - 0x65 evicts the LRU way0 (dirty).
  - WRITEBACK occurs with mem_address=0x09 and byte1=0xAB, followed by FETCH 0x19.
- Fill both ways, hit way0, then miss in the same set -> way1 is replaced; way0 data is retained.
- Assert reset during FETCH -> mem_read drops the same cycle; a following read of the same address misses again.
- Hold read && write together on a hit -> treated as a write; readdata is unchanged until the write edge.

Source files
------------

// File: rtl/dcache_assoc.sv
// Write-back, write-allocate set-associative data cache (1 or 2 ways) with LRU replacement.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
module dcache_assoc #(
    parameter int ADDR_W      = 8,
    parameter int NUM_SETS    = 4,
    parameter int WAYS        = 2,
    parameter int BLOCK_BYTES = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   read,
    input  logic                                   write,
    input  logic [ADDR_W-1:0]                      address,
    input  logic [7:0]                             writedata,
    output logic [7:0]                             readdata,
    output logic                                   busywait,
    output logic                                   mem_read,
    output logic                                   mem_write,
    output logic [ADDR_W-$clog2(BLOCK_BYTES)-1:0]  mem_address,
    output logic [8*BLOCK_BYTES-1:0]               mem_writedata,
    input  logic [8*BLOCK_BYTES-1:0]               mem_readdata,
    input  logic                                   mem_busywait
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]                            hit_count,
    output logic [15:0]                            miss_count
`endif
);

    localparam int OFF_W = $clog2(BLOCK_BYTES);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int BLK_W = 8 * BLOCK_BYTES;

    // IDLE: serve hits, detect misses | WRITEBACK: flush dirty victim | FETCH: refill victim
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITEBACK = 2'd1;
    localparam logic [1:0] S_FETCH     = 2'd2;

    logic [1:0]          state;
    logic                victim_way;
    logic [BLK_W-1:0]    data_arr  [WAYS][NUM_SETS];
    logic [TAG_W-1:0]    tag_arr   [WAYS][NUM_SETS];
    logic [NUM_SETS-1:0] valid_arr [WAYS];
    logic [NUM_SETS-1:0] dirty_arr [WAYS];
    logic [NUM_SETS-1:0] lru;

    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    req_idx;
    logic [OFF_W-1:0]    req_off;
    logic                access;
    logic                in_idle;
    logic                hit;
    logic                hit_way;
    logic                pick_way;
    logic                victim_dirty;
    logic                refill_done;
    logic [BLK_W-1:0]    hit_line;

    assign req_tag = address[ADDR_W-1 -: TAG_W];
    assign req_idx = address[OFF_W +: IDX_W];
    assign req_off = address[OFF_W-1:0];

    assign access      = read | write;
    assign in_idle     = (state == S_IDLE);
    assign refill_done = (state == S_FETCH) && !mem_busywait;

    always_comb begin
        hit     = 1'b0;
        hit_way = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_arr[w][req_idx] && (tag_arr[w][req_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = 1'(w);
            end
        end
    end

    // Lowest-numbered invalid way wins; otherwise fall back to the LRU way.
    always_comb begin
        pick_way = (WAYS > 1) ? lru[req_idx] : 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_arr[w][req_idx]) pick_way = 1'(w);
        end
    end

    assign victim_dirty = valid_arr[pick_way][req_idx] && dirty_arr[pick_way][req_idx];
    assign hit_line     = data_arr[hit_way][req_idx];
    assign readdata     = hit ? hit_line[{req_off, 3'b000} +: 8] : 8'h00;
    assign busywait     = access && !(in_idle && hit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            victim_way <= 1'b0;
            lru        <= '0;
            for (int w = 0; w < WAYS; w++) begin
                valid_arr[w] <= '0;
                dirty_arr[w] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (access && hit) begin
                        if (WAYS > 1) lru[req_idx] <= ~hit_way;
                        if (write) dirty_arr[hit_way][req_idx] <= 1'b1;
                    end else if (access) begin
                        victim_way <= pick_way;
                        state      <= victim_dirty ? S_WRITEBACK : S_FETCH;
                    end
                end
                S_WRITEBACK: begin
                    if (!mem_busywait) state <= S_FETCH;
                end
                S_FETCH: begin
                    if (!mem_busywait) begin
                        valid_arr[victim_way][req_idx] <= 1'b1;
                        dirty_arr[victim_way][req_idx] <= 1'b0;
                        state                          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Data and tags carry no reset; a refill cut short by reset is discarded via the valid bits.
    always_ff @(posedge clk) begin
        if (refill_done) begin
            data_arr[victim_way][req_idx] <= mem_readdata;
            tag_arr[victim_way][req_idx]  <= req_tag;
        end else if (in_idle && write && hit) begin
            data_arr[hit_way][req_idx][{req_off, 3'b000} +: 8] <= writedata;
        end
    end

    always_comb begin
        mem_read      = (state == S_FETCH);
        mem_write     = (state == S_WRITEBACK);
        mem_address   = '0;
        mem_writedata = '0;
        if (state == S_WRITEBACK) begin
            mem_address   = {tag_arr[victim_way][req_idx], req_idx};
            mem_writedata = data_arr[victim_way][req_idx];
        end else if (state == S_FETCH) begin
            mem_address   = {req_tag, req_idx};
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (in_idle && access && hit && (hit_count != 16'hFFFF))
                hit_count <= hit_count + 16'd1;
            if (in_idle && access && !hit && (miss_count != 16'hFFFF))
                miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_assoc.sv
// Scoreboard bench for dcache_assoc: directed accesses push expected memory
// transactions and CPU completions; a negedge monitor pops and compares them.
module tb_dcache_assoc;

    localparam int LAT = 5;

    logic        clk;
    logic        reset;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
    logic [15:0] hc0;
    logic [15:0] mc0;
`endif

    dcache_assoc dut (
        .clk          (clk),
        .reset        (reset),
        .read         (read),
        .write        (write),
        .address      (address),
        .writedata    (writedata),
        .readdata     (readdata),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_writedata(mem_writedata),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: byte at address a holds a ^ 8'hC3 until written back.
    logic [31:0] mem [64];
    int          mcnt = 0;

    assign mem_busywait = (mem_read | mem_write) && (mcnt != LAT - 1);
    assign mem_readdata = mem[mem_address];

    always @(posedge clk) begin
        if (!(mem_read | mem_write) || mcnt == LAT - 1) mcnt <= 0;
        else mcnt <= mcnt + 1;
        if (mem_write && !mem_busywait) mem[mem_address] <= mem_writedata;
    end

    typedef struct {
        string      name;
        int         kind;   // 0 cpu completion, 1 fetch, 2 writeback
        logic [7:0] a;
        logic [7:0] b;
        int         n;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;
    int   stall = 0;
    logic prev_mr = 1'b0;
    logic prev_mw = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push(input string nm, input int kind, input logic [7:0] a,
                        input logic [7:0] b, input int n);
        exp_t x;
        x.name = nm; x.kind = kind; x.a = a; x.b = b; x.n = n;
        q.push_back(x);
    endtask

    task automatic pop_or_fail(input string what, output logic ok);
        ok = 1'b1;
        if (q.size() == 0) begin
            total++;
            bad++;
            ok = 1'b0;
            $display("FAIL unexpected_%s: got event with empty queue, required none", what);
        end else begin
            e = q.pop_front();
        end
    endtask

    always @(negedge clk) begin
        logic ok;
        if (reset) begin
            stall   = 0;
            prev_mr = 1'b0;
            prev_mw = 1'b0;
        end else begin
            chk("strobe_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
            if (mem_write && !prev_mw) begin
                pop_or_fail("writeback", ok);
                if (ok) begin
                    chk({e.name, "_kind"}, e.kind, 2);
                    chk({e.name, "_wb_addr"}, {26'd0, mem_address}, {24'd0, e.a});
                    chk({e.name, "_wb_byte1"}, {24'd0, mem_writedata[15:8]}, {24'd0, e.b});
                end
            end
            if (mem_read && !prev_mr) begin
                pop_or_fail("fetch", ok);
                if (ok) begin
                    chk({e.name, "_kind"}, e.kind, 1);
                    chk({e.name, "_fetch_addr"}, {26'd0, mem_address}, {24'd0, e.a});
                end
            end
            if (read | write) begin
                if (busywait) stall++;
                else begin
                    pop_or_fail("completion", ok);
                    if (ok) begin
                        chk({e.name, "_kind"}, e.kind, 0);
                        chk({e.name, "_readdata"}, {24'd0, readdata}, {24'd0, e.a});
                        chk({e.name, "_stall"}, stall, e.n);
                    end
                    stall = 0;
                end
            end
            prev_mr = mem_read;
            prev_mw = mem_write;
        end
    end

    task automatic access(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        int n;
        read = r; write = w; address = a; writedata = d;
        n = 0;
        @(negedge clk);
        while (busywait && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busywait) begin
            total++;
            bad++;
            $display("FAIL access_timeout addr=%0h: got busywait=1, required 0", a);
        end
        @(posedge clk);
        #1;
        read = 1'b0; write = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 64; i++)
            for (int k = 0; k < 4; k++)
                mem[i][k*8 +: 8] = 8'(i*4 + k) ^ 8'hC3;
        reset = 1'b1; read = 1'b0; write = 1'b0; address = 8'h00; writedata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busywait", {31'd0, busywait}, 32'd0);
        chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_mem_address", {26'd0, mem_address}, 32'd0);
        chk("rst_mem_writedata", mem_writedata, 32'd0);
        chk("rst_readdata", {24'd0, readdata}, 32'd0);
`ifdef DCACHE_STATS_EN
        chk("rst_hit_count", {16'd0, hit_count}, 32'd0);
        chk("rst_miss_count", {16'd0, miss_count}, 32'd0);
`endif
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Cold miss, then hit in the same block.
        push("cold_25", 1, 8'h09, 8'h00, 0);
        push("cold_25", 0, 8'hE6, 8'h00, 6);
        access(1'b1, 1'b0, 8'h25, 8'h00);
`ifdef DCACHE_STATS_EN
        hc0 = hit_count; mc0 = miss_count;
`endif
        push("hit_24", 0, 8'hE7, 8'h00, 0);
        access(1'b1, 1'b0, 8'h24, 8'h00);
`ifdef DCACHE_STATS_EN
        chk("hit_24_hit_delta", {16'd0, hit_count - hc0}, 32'd1);
        chk("hit_24_miss_delta", {16'd0, miss_count - mc0}, 32'd0);
`endif

        // Write hit makes way0 of set1 dirty; readdata shows the old byte until the edge.
        push("wr_25", 0, 8'hE6, 8'h00, 0);
        access(1'b0, 1'b1, 8'h25, 8'hAB);
        push("rd_25", 0, 8'hAB, 8'h00, 0);
        access(1'b1, 1'b0, 8'h25, 8'h00);

`ifdef DCACHE_STATS_EN
        mc0 = miss_count;
`endif
        push("fill_45", 1, 8'h11, 8'h00, 0);
        push("fill_45", 0, 8'h86, 8'h00, 6);
        access(1'b1, 1'b0, 8'h45, 8'h00);
`ifdef DCACHE_STATS_EN
        chk("fill_45_miss_delta", {16'd0, miss_count - mc0}, 32'd1);
`endif

        // 0x65 evicts dirty LRU way0 (block 0x09).
        push("evict_65", 2, 8'h09, 8'hAB, 0);
        push("evict_65", 1, 8'h19, 8'h00, 0);
        push("evict_65", 0, 8'hA6, 8'h00, 11);
        access(1'b1, 1'b0, 8'h65, 8'h00);

        // Written-back byte comes back from memory; LRU now picks way1 (0x45).
        push("refetch_25", 1, 8'h09, 8'h00, 0);
        push("refetch_25", 0, 8'hAB, 8'h00, 6);
        access(1'b1, 1'b0, 8'h25, 8'h00);
        push("keep_65", 0, 8'hA6, 8'h00, 0);
        access(1'b1, 1'b0, 8'h65, 8'h00);

        // Set 2: fill both ways, touch way0, miss replaces way1.
        push("fill_08", 1, 8'h02, 8'h00, 0);
        push("fill_08", 0, 8'hCB, 8'h00, 6);
        access(1'b1, 1'b0, 8'h08, 8'h00);
        push("fill_18", 1, 8'h06, 8'h00, 0);
        push("fill_18", 0, 8'hDB, 8'h00, 6);
        access(1'b1, 1'b0, 8'h18, 8'h00);
        push("hit_0a", 0, 8'hC9, 8'h00, 0);
        access(1'b1, 1'b0, 8'h0A, 8'h00);
        push("miss_28", 1, 8'h0A, 8'h00, 0);
        push("miss_28", 0, 8'hEB, 8'h00, 6);
        access(1'b1, 1'b0, 8'h28, 8'h00);
        push("kept_09", 0, 8'hCA, 8'h00, 0);
        access(1'b1, 1'b0, 8'h09, 8'h00);

        // read && write together acts as a write.
        push("rw_09", 0, 8'hCA, 8'h00, 0);
        access(1'b1, 1'b1, 8'h09, 8'h5C);
        push("after_rw_09", 0, 8'h5C, 8'h00, 0);
        access(1'b1, 1'b0, 8'h09, 8'h00);

        // Reset during FETCH.
        push("rst_fetch_33", 1, 8'h0C, 8'h00, 0);
        read = 1'b1; address = 8'h33;
        n = 0;
        @(negedge clk);
        while (!mem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_fetch_started", {31'd0, mem_read}, 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst_mid_mem_address", {26'd0, mem_address}, 32'd0);
        chk("rst_mid_busywait", {31'd0, busywait}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0; read = 1'b0;

        push("again_33", 1, 8'h0C, 8'h00, 0);
        push("again_33", 0, 8'hF0, 8'h00, 6);
        access(1'b1, 1'b0, 8'h33, 8'h00);
        // Dirty 0x5C line was invalidated without write-back.
        push("inval_09", 1, 8'h02, 8'h00, 0);
        push("inval_09", 0, 8'hCA, 8'h00, 6);
        access(1'b1, 1'b0, 8'h09, 8'h00);

        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
